// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM
// state encoding and store lane/misalignment helpers.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] store_wbe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << {off[1], 1'b0};
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the narrow operand across all lanes; the byte enables pick the lane.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H:    return off[0];
      F3_HU:   return !we && off[0];
      F3_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half lane from the read word
// and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: IDLE/REQ/RESP handshake with a word-addressed data
// memory. Optional misalignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access
  import mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [3:0]        mem_wbe,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DWIDTH-1:0] wb_data
`ifdef MEM_MISALIGN_CHECK_EN
  ,
`else
  ,
`endif
  output logic              misalign
);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [1:0]          off_q;
  logic [3:0]          wbe_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q;
  logic                wb_valid_q;
  logic [4:0]          wb_rd_q;
  logic [DWIDTH-1:0]   wb_data_q;
  logic                misalign_q;
  logic                accept;
  logic                bad_align;
  logic [DWIDTH-1:0]   load_data;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[DWIDTH-1:AWIDTH+2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign bad_align = misaligned(req_we, req_funct3, req_addr[1:0]);
`else
  // Without the check, low offset bits are simply ignored by the lane logic.
  assign bad_align = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && !bad_align) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = we_q ? IDLE : RESP;
      RESP:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .data   (load_data)
  );

  // NOTE: the datapath registers are reset as well because wb_rd/wb_data must
  // read zero after reset, not merely be qualified by wb_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      off_q      <= '0;
      wbe_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      if (accept) begin
        addr_q     <= req_addr[AWIDTH+1:2];
        off_q      <= req_addr[1:0];
        wbe_q      <= req_we ? store_wbe(req_funct3, req_addr[1:0]) : 4'b0000;
        wdata_q    <= store_data(req_funct3, req_wdata);
        we_q       <= req_we;
        f3_q       <= req_funct3;
        rd_q       <= req_rd;
        misalign_q <= bad_align;
      end
      if ((state_q == RESP) && mem_rvalid) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_data_q  <= load_data;
      end
    end
  end

  // Request fields are only visible while the request is pending.
  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = mem_req_valid ? addr_q  : '0;
  assign mem_wbe       = mem_req_valid ? wbe_q   : '0;
  assign mem_wdata     = mem_req_valid ? wdata_q : '0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;

endmodule
